// File: rtl/range_stream_sender.sv
// FIFO-buffered sample sender: on send, streams all buffered samples with go/finish
// framing, then reports the unsigned max-min range of the stream in a one-cycle GAP.
module range_stream_sender #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic                     send,
  output logic [WIDTH-1:0]         data_out,
  output logic                     go,
  output logic                     finish,
  output logic                     busy,
  output logic                     done,
  output logic                     reject,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         expected_range
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, STREAM, GAP} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d, eff_count;
  logic [WIDTH-1:0]  data_q, data_d, max_q, max_d, min_q, min_d, range_q, range_d;
  logic              go_q, go_d, finish_q, finish_d, done_q, done_d, reject_q, reject_d;
  logic              wr_acc;
  logic [WIDTH-1:0]  head;

  function automatic logic [WIDTH-1:0] umax(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [WIDTH-1:0] umin(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [WIDTH-1:0] span(input logic [WIDTH-1:0] hi, input logic [WIDTH-1:0] lo);
    return hi - lo;
  endfunction

  always_comb begin
    wr_acc    = wr_valid && (state_q == IDLE) && (count_q < CW'(DEPTH));
    // A write accepted alongside send joins the stream as its last sample.
    eff_count = count_q + CW'(wr_acc);
    head      = mem[rd_ptr_q];

    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    data_d   = '0;
    go_d     = 1'b0;
    finish_d = 1'b0;
    done_d   = 1'b0;
    reject_d = 1'b0;
    max_d    = max_q;
    min_d    = min_q;
    range_d  = range_q;

    if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);

    case (state_q)
      IDLE: begin
        count_d = eff_count;
        if (send) begin
          if (eff_count >= CW'(2)) begin
            state_d  = STREAM;
            data_d   = head;
            go_d     = 1'b1;
            rd_ptr_d = rd_ptr_q + PW'(1);
            count_d  = eff_count - CW'(1);
            max_d    = head;
            min_d    = head;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      STREAM: begin
        if (count_q != '0) begin
          data_d   = head;
          finish_d = (count_q == CW'(1));
          rd_ptr_d = rd_ptr_q + PW'(1);
          count_d  = count_q - CW'(1);
          max_d    = umax(max_q, head);
          min_d    = umin(min_q, head);
        end else begin
          state_d = GAP;
          done_d  = 1'b1;
          range_d = span(max_q, min_q);
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      go_q     <= 1'b0;
      finish_q <= 1'b0;
      done_q   <= 1'b0;
      reject_q <= 1'b0;
      max_q    <= '0;
      min_q    <= '0;
      range_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      go_q     <= go_d;
      finish_q <= finish_d;
      done_q   <= done_d;
      reject_q <= reject_d;
      max_q    <= max_d;
      min_q    <= min_d;
      range_q  <= range_d;
    end
  end

  // Sample storage carries no reset; count and pointers define what is valid.
  always_ff @(posedge clock) begin
    if (wr_acc) mem[wr_ptr_q] <= wr_data;
  end

  assign wr_ready       = (state_q == IDLE) && (count_q < CW'(DEPTH));
  assign busy           = (state_q != IDLE);
  assign data_out       = data_q;
  assign go             = go_q;
  assign finish         = finish_q;
  assign done           = done_q;
  assign reject         = reject_q;
  assign count          = count_q;
  assign expected_range = range_q;

endmodule

// File: doc/range_stream_sender.md
RANGE_STREAM_SENDER -- requirements
Module: range_stream_sender

Interface
REQ-001 Parameter WIDTH, default 16, sample width in bits.
REQ-002 Parameter DEPTH, default 8, sample buffer capacity (power of two, at least 2).
REQ-003 clock  input  1  rising-edge clock, named clock.
REQ-004 reset  input  1  named reset; asynchronous, active-high.
REQ-005 wr_data  input  WIDTH  sample to load into the buffer.
REQ-006 wr_valid  input  1  load request; sample accepted on a rising edge when wr_valid and wr_ready are both 1.
REQ-007 wr_ready  output  1  combinational; 1 only in IDLE with count < DEPTH.
REQ-008 send  input  1  start request for transmission of all buffered samples.
REQ-009 data_out  output  WIDTH  registered stream sample; 0 when not streaming.
REQ-010 go  output  1  registered; marks the first sample of a stream.
REQ-011 finish  output  1  registered; marks the last sample of a stream.
REQ-012 busy  output  1  1 in any state other than IDLE.
REQ-013 done  output  1  registered one-cycle pulse in the GAP cycle.
REQ-014 reject  output  1  registered one-cycle pulse when send is refused.
REQ-015 count  output  $clog2(DEPTH)+1  number of buffered samples.
REQ-016 expected_range  output  WIDTH  unsigned max-min of the last transmitted stream; held until the next done.

Function
REQ-017 The buffer shall be a FIFO; samples are transmitted in load order.
REQ-018 The FSM states shall be IDLE, STREAM, GAP.
REQ-019 In IDLE, send with effective count >= 2 shall move to STREAM; effective count = count + 1 when a write is accepted in the same cycle (that sample is included as last), else count.
REQ-020 In IDLE, send with effective count < 2 shall pulse reject the next cycle, stay in IDLE, and keep buffer contents (including a same-cycle accepted write).
REQ-021 send in STREAM or GAP shall be ignored, with no reject.
REQ-022 For a stream of N samples accepted at edge t: cycle t+1 data_out = sample 0, go=1, finish=0; cycle t+1+k data_out = sample k, go=0; cycle t+N data_out = sample N-1, finish=1.
REQ-023 go and finish shall never both be 1 in the same cycle; go shall be 1 for exactly one cycle per stream.
REQ-024 Cycle t+N+1 shall be GAP: go=finish=0, data_out=0, done=1, expected_range updated, count=0.
REQ-025 The FSM shall return to IDLE at t+N+2; the earliest next go is therefore t+N+3, guaranteeing at least two idle cycles between finish and the next go.
REQ-026 Writes shall not be accepted while busy; wr_valid while full or busy shall be dropped without side effect.
REQ-027 count shall decrement by one for each sample emitted, reaching 0 in the GAP cycle.
REQ-028 The running max/min shall be tracked as unsigned values over the samples emitted; expected_range = max - min, which is never negative.
REQ-029 A stream of identical samples shall give expected_range = 0.
REQ-030 FIFO pointers shall wrap modulo DEPTH; a full buffer (count = DEPTH) shall be transmittable as a single stream.

Reset
REQ-031 Asserting reset at any time, including mid-stream, shall immediately force IDLE, empty the FIFO (count=0), and set go, finish, data_out, done, reject and expected_range to 0, with busy=0 and wr_ready=1.
REQ-032 After reset deasserts, the next stream shall start with go; no partial stream shall resume.

Verification
REQ-033 Load 5, 9, 2, 7, then send -> go with 5; then 9, 2; finish with 7; done next cycle; expected_range=7; count=0.
REQ-034 Load a single sample 4, then send -> reject pulse, no go, count=1; load 4 more, then send -> 4,4 streamed, expected_range=0.
REQ-035 Load 8 samples (full); a 9th wr_valid is dropped with wr_ready=0; send -> exactly 8 samples with finish on the 8th; pointers wrap correctly on the next fill.
REQ-036 Load 1 sample and assert send together with wr_valid of a second sample -> accepted; 2-sample stream where go and finish fall in consecutive cycles.
REQ-037 Assert reset during the third sample of a 6-sample stream -> outputs 0 in the same cycle, count=0; a new 3-sample load and send produce a clean go...finish.
REQ-038 Assert send repeatedly during STREAM -> ignored; next go no earlier than two cycles after finish.
